// File: rtl/mole_round_engine.sv
// Whack-a-mole round engine: IDLE/GAP/UP sequencing, LFSR mole pick, hit/miss scoring.
// Optional MOLE_NO_REPEAT_EN: never light the same mole in two consecutive rounds.
module mole_round_engine #(
  parameter int unsigned NUM_MOLES = 3,
  parameter int unsigned CNT_W     = 28,
  parameter int unsigned SCORE_W   = 8,
  parameter logic [7:0]  LFSR_SEED = 8'hA5
) (
  input  logic                 clock,
  input  logic                 resetn,
  input  logic                 game,
  input  logic [NUM_MOLES-1:0] buttons,
  input  logic [CNT_W-1:0]     gap_cycles,
  input  logic [CNT_W-1:0]     up_cycles,
  output logic [NUM_MOLES-1:0] moles,
  output logic [SCORE_W-1:0]   score,
  output logic [SCORE_W-1:0]   misses,
  output logic                 hit,
  output logic                 miss
);

  localparam int unsigned IDX_W = (NUM_MOLES > 2) ? $clog2(NUM_MOLES) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GAP  = 2'd1,
    ST_UP   = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [7:0]           lfsr_q, lfsr_d;
  logic [NUM_MOLES-1:0] buttons_q, buttons_d;
  logic                 game_q, game_d;
  logic [NUM_MOLES-1:0] moles_q, moles_d;
  logic [SCORE_W-1:0]   score_q, score_d;
  logic [SCORE_W-1:0]   misses_q, misses_d;
  logic                 hit_q, hit_d;
  logic                 miss_q, miss_d;

  logic [NUM_MOLES-1:0] btn_edge;
  logic                 hit_edge;
  logic                 wrong_edge;
  logic                 lfsr_fb;
  logic [IDX_W-1:0]     raw_idx;
  logic [IDX_W-1:0]     red_idx;
  logic [IDX_W-1:0]     new_idx;
  logic [NUM_MOLES-1:0] new_moles;
  logic [CNT_W-1:0]     gap_load;
  logic [CNT_W-1:0]     up_load;
  logic [SCORE_W-1:0]   score_inc;
  logic [SCORE_W-1:0]   score_dec;
  logic [SCORE_W-1:0]   misses_inc;

`ifdef MOLE_NO_REPEAT_EN
  logic [IDX_W-1:0]     last_idx_q, last_idx_d;
`endif

  // Free-running LFSR; an all-zero state is recovered by reloading the seed.
  always_comb begin
    lfsr_fb = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];
    lfsr_d  = (lfsr_q == 8'h00) ? LFSR_SEED : {lfsr_q[6:0], lfsr_fb};
  end

  // Mole pick: low LFSR bits folded into range with a single subtraction.
  always_comb begin
    raw_idx = lfsr_q[IDX_W-1:0];
    red_idx = (32'(raw_idx) >= NUM_MOLES) ? (raw_idx - IDX_W'(NUM_MOLES)) : raw_idx;
`ifdef MOLE_NO_REPEAT_EN
    if (red_idx == last_idx_q) begin
      new_idx = ((32'(red_idx) + 32'd1) == NUM_MOLES) ? '0 : (red_idx + IDX_W'(1));
    end else begin
      new_idx = red_idx;
    end
`else
    new_idx = red_idx;
`endif
    new_moles = NUM_MOLES'(1) << new_idx;
  end

  // Edge detection, duration loads (0 behaves as 1) and saturating arithmetic.
  always_comb begin
    btn_edge   = buttons & ~buttons_q;
    hit_edge   = |(btn_edge & moles_q);
    wrong_edge = |(btn_edge & ~moles_q);
    gap_load   = (gap_cycles == '0) ? CNT_W'(1) : gap_cycles;
    up_load    = (up_cycles == '0) ? CNT_W'(1) : up_cycles;
    score_inc  = (&score_q) ? score_q : (score_q + SCORE_W'(1));
    score_dec  = (score_q == '0) ? score_q : (score_q - SCORE_W'(1));
    misses_inc = (&misses_q) ? misses_q : (misses_q + SCORE_W'(1));
  end

  // Round FSM next-state and registered-output logic.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    moles_d   = moles_q;
    score_d   = score_q;
    misses_d  = misses_q;
    hit_d     = 1'b0;
    miss_d    = 1'b0;
    buttons_d = buttons;
    game_d    = game;
`ifdef MOLE_NO_REPEAT_EN
    last_idx_d = last_idx_q;
`endif

    if (!game) begin
      state_d = ST_IDLE;
      moles_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          moles_d = '0;
          if (!game_q) begin
            state_d  = ST_GAP;
            cnt_d    = gap_load;
            score_d  = '0;
            misses_d = '0;
          end
        end

        ST_GAP: begin
          if (cnt_q <= CNT_W'(1)) begin
            state_d = ST_UP;
            cnt_d   = up_load;
            moles_d = new_moles;
`ifdef MOLE_NO_REPEAT_EN
            last_idx_d = new_idx;
`endif
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end

        ST_UP: begin
          // A correct edge overrides both the wrong-press penalty and expiry.
          if (hit_edge) begin
            state_d = ST_GAP;
            cnt_d   = gap_load;
            moles_d = '0;
            score_d = score_inc;
            hit_d   = 1'b1;
          end else begin
            if (wrong_edge) begin
              score_d = score_dec;
            end
            if (cnt_q <= CNT_W'(1)) begin
              state_d  = ST_GAP;
              cnt_d    = gap_load;
              moles_d  = '0;
              misses_d = misses_inc;
              miss_d   = 1'b1;
            end else begin
              cnt_d = cnt_q - CNT_W'(1);
            end
          end
        end

        default: begin
          state_d = ST_IDLE;
          moles_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      lfsr_q    <= LFSR_SEED;
      buttons_q <= '0;
      game_q    <= 1'b0;
      moles_q   <= '0;
      score_q   <= '0;
      misses_q  <= '0;
      hit_q     <= 1'b0;
      miss_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      lfsr_q    <= lfsr_d;
      buttons_q <= buttons_d;
      game_q    <= game_d;
      moles_q   <= moles_d;
      score_q   <= score_d;
      misses_q  <= misses_d;
      hit_q     <= hit_d;
      miss_q    <= miss_d;
    end
  end

`ifdef MOLE_NO_REPEAT_EN
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      last_idx_q <= '0;
    end else begin
      last_idx_q <= last_idx_d;
    end
  end
`endif

  assign moles  = moles_q;
  assign score  = score_q;
  assign misses = misses_q;
  assign hit    = hit_q;
  assign miss   = miss_q;

endmodule

// File: tb/tb_mole_round_engine.sv
// Directed bench for mole_round_engine (NUM_MOLES=3, SCORE_W=2) with a reference LFSR pick model.
module tb_mole_round_engine;

  localparam int N  = 3;
  localparam int CW = 28;
  localparam int SW = 2;

  logic          clock = 1'b0;
  logic          resetn;
  logic          game;
  logic [N-1:0]  buttons;
  logic [CW-1:0] gap_cycles;
  logic [CW-1:0] up_cycles;
  logic [N-1:0]  moles;
  logic [SW-1:0] score;
  logic [SW-1:0] misses;
  logic          hit;
  logic          miss;

  int            n_checks = 0;
  int            n_fail   = 0;
  logic [7:0]    m_lfsr;
  int            loaded_gap;
  int            loaded_up;
  logic [SW-1:0] exp_score;
  logic [SW-1:0] exp_misses;
`ifdef MOLE_NO_REPEAT_EN
  int            m_last = 0;
`endif

  mole_round_engine #(
    .NUM_MOLES (N),
    .CNT_W     (CW),
    .SCORE_W   (SW),
    .LFSR_SEED (8'hA5)
  ) dut (
    .clock      (clock),
    .resetn     (resetn),
    .game       (game),
    .buttons    (buttons),
    .gap_cycles (gap_cycles),
    .up_cycles  (up_cycles),
    .moles      (moles),
    .score      (score),
    .misses     (misses),
    .hit        (hit),
    .miss       (miss)
  );

  always #5 clock = ~clock;

  // Reference LFSR: x^8 taps 7,5,4,3, shifting left every cycle.
  always @(posedge clock or negedge resetn) begin
    if (!resetn) m_lfsr <= 8'hA5;
    else if (m_lfsr == 8'h00) m_lfsr <= 8'hA5;
    else m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
  end

  function automatic int eff(input logic [CW-1:0] v);
    return (v == '0) ? 1 : int'(v);
  endfunction

  function automatic logic [SW-1:0] sat_inc(input logic [SW-1:0] v);
    return (&v) ? v : v + SW'(1);
  endfunction

  function automatic logic [SW-1:0] sat_dec(input logic [SW-1:0] v);
    return (v == '0) ? v : v - SW'(1);
  endfunction

  function automatic logic [N-1:0] pick();
    int idx;
    idx = int'(m_lfsr[1:0]);
    if (idx >= N) idx -= N;
`ifdef MOLE_NO_REPEAT_EN
    if (idx == m_last) idx = (idx + 1 == N) ? 0 : idx + 1;
    m_last = idx;
`endif
    return N'(1) << idx;
  endfunction

  // From the negedge after GAP entry: dark for the loaded gap length, then the predicted mole.
  task automatic run_gap(output logic [N-1:0] exp);
    exp = '0;
    for (int i = 0; i < loaded_gap; i++) begin
      n_checks++;
      if (moles !== '0) begin
        n_fail++;
        $display("FAIL gap_dark: cycle %0d moles=%b required 000", i, moles);
      end
      if (i > 0) begin
        n_checks++;
        if ({hit, miss} !== 2'b00) begin
          n_fail++;
          $display("FAIL gap_no_pulse: cycle %0d hit=%b miss=%b required 0 0", i, hit, miss);
        end
      end
      if (i == loaded_gap - 1) begin
        exp       = pick();
        loaded_up = eff(up_cycles);
      end
      @(negedge clock);
    end
    n_checks++;
    if (moles !== exp) begin
      n_fail++;
      $display("FAIL up_lit: moles=%b required %b", moles, exp);
    end
  endtask

  // From the negedge after UP entry: mole stays lit for the loaded up length, then a miss.
  task automatic run_up_timeout(input logic [N-1:0] exp);
    for (int i = 1; i < loaded_up; i++) begin
      @(negedge clock);
      n_checks++;
      if ({moles, miss} !== {exp, 1'b0}) begin
        n_fail++;
        $display("FAIL up_hold: cycle %0d moles=%b miss=%b required %b 0", i, moles, miss, exp);
      end
    end
    @(negedge clock);
    exp_misses = sat_inc(exp_misses);
    loaded_gap = eff(gap_cycles);
    n_checks++;
    if ({moles, hit, miss} !== {N'(0), 2'b01}) begin
      n_fail++;
      $display("FAIL timeout_pulse: moles=%b hit=%b miss=%b required 000 0 1", moles, hit, miss);
    end
    n_checks++;
    if ({misses, score} !== {exp_misses, exp_score}) begin
      n_fail++;
      $display("FAIL timeout_counts: misses=%0d score=%0d required %0d %0d",
               misses, score, exp_misses, exp_score);
    end
  endtask

  task automatic press_hit(input logic [N-1:0] btn);
    buttons = btn;
    @(negedge clock);
    buttons    = '0;
    exp_score  = sat_inc(exp_score);
    loaded_gap = eff(gap_cycles);
    n_checks++;
    if ({moles, hit, miss} !== {N'(0), 2'b10}) begin
      n_fail++;
      $display("FAIL hit_pulse: moles=%b hit=%b miss=%b required 000 1 0", moles, hit, miss);
    end
    n_checks++;
    if ({score, misses} !== {exp_score, exp_misses}) begin
      n_fail++;
      $display("FAIL hit_counts: score=%0d misses=%0d required %0d %0d",
               score, misses, exp_score, exp_misses);
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (2) @(negedge clock);
    n_checks++;
    if ({moles, score, misses, hit, miss} !== '0) begin
      n_fail++;
      $display("FAIL reset_values: moles=%b score=%0d misses=%0d hit=%b miss=%b required all 0",
               moles, score, misses, hit, miss);
    end
    resetn = 1'b1;
    @(negedge clock);
    n_checks++;
    if ({moles, hit, miss} !== '0) begin
      n_fail++;
      $display("FAIL idle_dark: moles=%b hit=%b miss=%b required 0", moles, hit, miss);
    end
  endtask

  task automatic test_start_timeout();
    logic [N-1:0] exp;
    game = 1'b1;
    @(negedge clock);
    loaded_gap = eff(gap_cycles);
    run_gap(exp);
    run_up_timeout(exp);
  endtask

  task automatic test_hit();
    logic [N-1:0] exp;
    run_gap(exp);
    @(negedge clock);
    n_checks++;
    if (moles !== exp) begin
      n_fail++;
      $display("FAIL hit_up2_lit: moles=%b required %b", moles, exp);
    end
    press_hit(exp);
  endtask

  task automatic test_wrong_press();
    logic [N-1:0] exp;
    logic [N-1:0] w;
    up_cycles = 20;
    run_gap(exp);
    w = {exp[N-2:0], exp[N-1]};
    for (int k = 0; k < 2; k++) begin
      buttons = w;
      @(negedge clock);
      buttons   = '0;
      exp_score = sat_dec(exp_score);
      n_checks++;
      if ({score, moles, hit} !== {exp_score, exp, 1'b0}) begin
        n_fail++;
        $display("FAIL wrong_press_%0d: score=%0d moles=%b hit=%b required %0d %b 0",
                 k, score, moles, hit, exp_score, exp);
      end
      @(negedge clock);
    end
    press_hit(exp);
  endtask

  task automatic test_saturation();
    logic [N-1:0] exp;
    gap_cycles = 1;
    up_cycles  = 5;
    repeat (5) begin
      run_gap(exp);
      press_hit(exp);
    end
    gap_cycles = 0;
    up_cycles  = 0;
    repeat (5) begin
      run_gap(exp);
      run_up_timeout(exp);
    end
  endtask

  task automatic test_simultaneous();
    logic [N-1:0] exp;
    logic [N-1:0] w2;
    gap_cycles = 2;
    up_cycles  = 20;
    run_gap(exp);
    w2 = ~exp;
    buttons = w2;
    @(negedge clock);
    buttons   = '0;
    exp_score = sat_dec(exp_score);
    n_checks++;
    if ({score, moles} !== {exp_score, exp}) begin
      n_fail++;
      $display("FAIL multi_wrong: score=%0d moles=%b required %0d %b", score, moles, exp_score, exp);
    end
    @(negedge clock);
    press_hit(exp | {exp[N-2:0], exp[N-1]});
    up_cycles = 1;
    run_gap(exp);
    press_hit(exp);
  endtask

  task automatic test_abort();
    logic [N-1:0] exp;
    up_cycles = 20;
    run_gap(exp);
    @(negedge clock);
    game = 1'b0;
    @(negedge clock);
    n_checks++;
    if ({moles, hit, miss} !== {N'(0), 2'b00}) begin
      n_fail++;
      $display("FAIL abort_dark: moles=%b hit=%b miss=%b required 000 0 0", moles, hit, miss);
    end
    n_checks++;
    if ({score, misses} !== {exp_score, exp_misses}) begin
      n_fail++;
      $display("FAIL abort_hold: score=%0d misses=%0d required %0d %0d",
               score, misses, exp_score, exp_misses);
    end
    repeat (2) @(negedge clock);
    n_checks++;
    if (moles !== '0) begin
      n_fail++;
      $display("FAIL idle_stays_dark: moles=%b required 000", moles);
    end
    game = 1'b1;
    @(negedge clock);
    exp_score  = '0;
    exp_misses = '0;
    loaded_gap = eff(gap_cycles);
    n_checks++;
    if ({score, misses, moles} !== '0) begin
      n_fail++;
      $display("FAIL restart_clear: score=%0d misses=%0d moles=%b required 0 0 000",
               score, misses, moles);
    end
    run_gap(exp);
    press_hit(exp);
  endtask

  task automatic test_async_reset();
    logic [N-1:0] exp;
    run_gap(exp);
    @(negedge clock);
    #2 resetn = 1'b0;
    #1;
    n_checks++;
    if ({moles, score, misses, hit, miss} !== '0) begin
      n_fail++;
      $display("FAIL async_reset: moles=%b score=%0d misses=%0d hit=%b miss=%b required all 0",
               moles, score, misses, hit, miss);
    end
    game = 1'b0;
`ifdef MOLE_NO_REPEAT_EN
    m_last = 0;
`endif
    @(negedge clock);
    resetn = 1'b1;
    @(negedge clock);
    game = 1'b1;
    @(negedge clock);
    exp_score  = '0;
    exp_misses = '0;
    loaded_gap = eff(gap_cycles);
    run_gap(exp);
    run_up_timeout(exp);
  endtask

`ifdef MOLE_NO_REPEAT_EN
  task automatic test_no_repeat();
    logic [N-1:0] exp;
    logic [N-1:0] prev;
    logic [N-1:0] seen;
    gap_cycles = 1;
    up_cycles  = 1;
    prev = '0;
    seen = '0;
    for (int r = 0; r < 200; r++) begin
      run_gap(exp);
      n_checks++;
      if (moles === prev) begin
        n_fail++;
        $display("FAIL no_repeat: round %0d moles=%b equals previous", r, moles);
      end
      prev = moles;
      seen = seen | moles;
      run_up_timeout(exp);
    end
    n_checks++;
    if (seen !== '1) begin
      n_fail++;
      $display("FAIL coverage_all: seen=%b required 111", seen);
    end
  endtask
`endif

  initial begin
    resetn     = 1'b0;
    game       = 1'b0;
    buttons    = '0;
    gap_cycles = 4;
    up_cycles  = 6;
    exp_score  = '0;
    exp_misses = '0;
    loaded_gap = 1;
    loaded_up  = 1;
    test_reset();
    test_start_timeout();
    test_hit();
    test_wrong_press();
    test_saturation();
    test_simultaneous();
    test_abort();
    test_async_reset();
`ifdef MOLE_NO_REPEAT_EN
    test_no_repeat();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
